vga_timing: RTL and testbench
=============================

# vga_timing

Raster timing generator for the iCE40 VGA device. It sits directly downstream of the PLL and global-buffer clock stage, and consumes the buffered PLL clock plus a pixel-rate enable. It produces registered horizontal/vertical sync, a visible-area flag, current pixel coordinates, and line/frame start strobes for the pixel-generation stage. Default parameters give 640x480@60 Hz, industry-standard 800x525 total raster.

## Interface

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)

Ports:
- clk  input  1  buffered global clock (`clk` from the SB_GB output). One clock domain. Reset is synchronous and active-high.
- rst  input  1  synchronous, active-high reset. Driven from `~pll_locked` at top level.
- pix_en  input  1  pixel advance enable. The raster advances one pixel per clk edge with pix_en=1.
- hsync  output  1  horizontal sync, level per HSYNC_POL
- vsync  output  1  vertical sync, level per VSYNC_POL
- visible  output  1  1 when the current position is in the active area
- x  output  10  current horizontal position, 0..H_TOTAL-1
- y  output  10  current vertical position, 0..V_TOTAL-1
- line_start  output  1  one-clk strobe when the position enters h=0
- frame_start  output  1  one-clk strobe when the position enters (0,0)

## Operation

- Derived totals:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (default 800).
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (default 525).
  - Both must be ≤ 1024.
- Position counters h and v are 10-bit unsigned registers. x = h and y = v, driven directly from the registers.
- Advance rule, applied on each clk edge with pix_en=1 and rst=0:
  - If h < H_TOTAL-1: h increments.
  - Else h → 0, and then: if v < V_TOTAL-1, v increments; else v → 0.
- With pix_en=0, h and v hold. No wrap occurs other than at H_TOTAL-1 and V_TOTAL-1.
- Decode outputs are registered and computed from the next position, so they always match the current x,y:
  - visible = (h < H_VISIBLE) && (v < V_VISIBLE)
  - hsync active iff H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC (default 656..751)
  - vsync active iff V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC (default 490..491). vsync spans whole lines and changes only at h=0 transitions.
- Strobes:
  - line_start = 1 for exactly one clk after an advancing edge that lands on h=0. Otherwise 0, including while pix_en holds the position.
  - frame_start = 1 for exactly one clk after an advancing edge that lands on (0,0). It always coincides with line_start.
- Reset:
  - Position is forced to (H_TOTAL-1, V_TOTAL-1), i.e. x=799, y=524, the last blanking pixel.
  - visible=0, hsync and vsync at inactive level (default 1), line_start=frame_start=0.
  - The first advance after reset lands on (0,0) and produces frame_start=1 and line_start=1.
- Reset mid-frame: takes effect on the next clk edge regardless of pix_en and restores the reset state above. rst has priority over pix_en.

## Timing

- Latency: every output changes on the same clk edge as the position change, with no additional pipeline delay. All outputs come from flops; no combinational path from inputs to outputs.
- pix_en may be any pattern, e.g. 1-in-N for clock division. Sync widths and porches scale in enabled cycles, not clk cycles.
- Frame period = H_TOTAL × V_TOTAL enabled cycles (default 420000).

## Test plan

- **Reset:** Assert rst for 3 clk with pix_en=1. Require x=799, y=524, visible=0, hsync=1, vsync=1, line_start=0, frame_start=0.
- **First advance:** Release rst, one pix_en. Require x=0, y=0, visible=1, frame_start=1 and line_start=1 for exactly one clk. With pix_en=0 on the next clk, both strobes return to 0 and x,y hold.
- **hsync edges:** Stepping through line 0, hsync goes 0 on x=656 and back to 1 on x=752. visible falls at x=640. line_start pulses at the wrap from x=799 to x=0 with y=1.
- **Full frame:** 420000 enables from (0,0) return to (0,0) with a single frame_start. Also require:
  - vsync=0 exactly for y=490..491 (1600 enabled cycles);
  - 525 line_start pulses;
  - visible asserted for 307200 enabled cycles.
- **Enable gating:** pix_en asserted every 4th clk. Require the hsync low width = 384 clk and the frame period = 1680000 clk.
- **Reset mid-frame:** At x=700, y=491 (hsync and vsync active), assert rst for 1 clk. Require the reset state on the next edge, and that the first subsequent advance gives frame_start at (0,0).

Source files
------------

// File: rtl/vga_timing.sv
// Raster timing generator: pixel position counters plus registered sync, visible and
// line/frame start strobes, all decoded from the next position so they align with x,y.
module vga_timing #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VLast     = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync region ending exactly at 1024 still compares correctly
  localparam logic [10:0] HVis      = 11'(H_VISIBLE);
  localparam logic [10:0] HSyncBeg  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HSyncEnd  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VVis      = 11'(V_VISIBLE);
  localparam logic [10:0] VSyncBeg  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VSyncEnd  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, vsync_q, visible_q, line_start_q, frame_start_q;
  logic       vis_d, hact_d, vact_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
    end
  end

  always_comb begin
    vis_d  = ({1'b0, h_d} < HVis) && ({1'b0, v_d} < VVis);
    hact_d = ({1'b0, h_d} >= HSyncBeg) && ({1'b0, h_d} < HSyncEnd);
    vact_d = ({1'b0, v_d} >= VSyncBeg) && ({1'b0, v_d} < VSyncEnd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= HLast;
      v_q           <= VLast;
      visible_q     <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // Strobes are single-cycle and drop while the position is held
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (pix_en) begin
        h_q           <= h_d;
        v_q           <= v_d;
        visible_q     <= vis_d;
        hsync_q       <= hact_d ? HSYNC_POL : ~HSYNC_POL;
        vsync_q       <= vact_d ? VSYNC_POL : ~VSYNC_POL;
        line_start_q  <= (h_d == '0);
        frame_start_q <= (h_d == '0) && (v_d == '0);
      end
    end
  end

  assign x           = h_q;
  assign y           = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign visible     = visible_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance and a small raster instance, both checked
// every clock against a linear pixel-index model, plus directed raster-level measurements.
module tb_vga_timing;

  typedef struct {
    int hvis, hfp, hsw, hbp;
    int vvis, vfp, vsw, vbp;
    bit hpol, vpol;
  } geom_t;

  logic       clk;
  logic       rst_a, en_a, rst_b, en_b;
  logic       hsync_a, vsync_a, vis_a, ls_a, fs_a;
  logic       hsync_b, vsync_b, vis_b, ls_b, fs_b;
  logic [9:0] x_a, y_a, x_b, y_b;

  int    errors = 0;
  int    checks = 0;
  geom_t ga, gb;
  int    pos_a, pos_b;
  bit    adv_a, adv_b, armed_a, armed_b;

  vga_timing u_dut_a (
    .clk(clk), .rst(rst_a), .pix_en(en_a), .hsync(hsync_a), .vsync(vsync_a),
    .visible(vis_a), .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .pix_en(en_b), .hsync(hsync_b), .vsync(vsync_b),
    .visible(vis_b), .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int htot(geom_t g);
    return g.hvis + g.hfp + g.hsw + g.hbp;
  endfunction

  function automatic int ftot(geom_t g);
    return htot(g) * (g.vvis + g.vfp + g.vsw + g.vbp);
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs derived from the linear pixel index within the frame
  task automatic check_dut(input string n, input geom_t g, input int pos, input bit adv,
                           input logic hs, input logic vs, input logic vis,
                           input logic [9:0] xo, input logic [9:0] yo,
                           input logic ls, input logic fs);
    int xe, ye;
    bit hact, vact;
    xe   = pos % htot(g);
    ye   = pos / htot(g);
    hact = (xe >= g.hvis + g.hfp) && (xe < g.hvis + g.hfp + g.hsw);
    vact = (ye >= g.vvis + g.vfp) && (ye < g.vvis + g.vfp + g.vsw);
    cmp({n, ".x"}, 32'(xo), 32'(xe));
    cmp({n, ".y"}, 32'(yo), 32'(ye));
    cmp({n, ".visible"}, 32'(vis), 32'((xe < g.hvis) && (ye < g.vvis)));
    cmp({n, ".hsync"}, 32'(hs), 32'(hact ? g.hpol : !g.hpol));
    cmp({n, ".vsync"}, 32'(vs), 32'(vact ? g.vpol : !g.vpol));
    cmp({n, ".line_start"}, 32'(ls), 32'(adv && xe == 0));
    cmp({n, ".frame_start"}, 32'(fs), 32'(adv && pos == 0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_a) begin pos_a = ftot(ga) - 1; adv_a = 0; armed_a = 1; end
    else if (en_a) begin pos_a = (pos_a + 1) % ftot(ga); adv_a = 1; end
    else adv_a = 0;
    if (rst_b) begin pos_b = ftot(gb) - 1; adv_b = 0; armed_b = 1; end
    else if (en_b) begin pos_b = (pos_b + 1) % ftot(gb); adv_b = 1; end
    else adv_b = 0;
    #1;
    if (armed_a) check_dut("a", ga, pos_a, adv_a, hsync_a, vsync_a, vis_a, x_a, y_a, ls_a, fs_a);
    if (armed_b) check_dut("b", gb, pos_b, adv_b, hsync_b, vsync_b, vis_b, x_b, y_b, ls_b, fs_b);
  endtask

  initial begin
    int fall_x, rise_x, visfall_x, ls_y, ls_x, low_cnt;
    int n_fs, n_ls, n_vs, n_vis, fs1, fs2;
    logic prev_hs, prev_vis;
    ga = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    gb = '{8, 2, 3, 2, 6, 1, 2, 1, 1'b1, 1'b0};
    armed_a = 0; armed_b = 0; adv_a = 0; adv_b = 0; pos_a = 0; pos_b = 0;
    rst_a = 1; en_a = 1; rst_b = 1; en_b = 0;

    // Reset with pix_en high
    repeat (3) tick();
    cmp("rst.x", 32'(x_a), 799);
    cmp("rst.y", 32'(y_a), 524);
    cmp("rst.hsync", 32'(hsync_a), 1);
    cmp("rst.vsync", 32'(vsync_a), 1);
    cmp("rst.visible", 32'(vis_a), 0);

    // First advance lands on (0,0) with both strobes, then holds
    rst_a = 0;
    tick();
    cmp("first.fs", 32'(fs_a), 1);
    cmp("first.ls", 32'(ls_a), 1);
    cmp("first.x", 32'(x_a), 0);
    cmp("first.vis", 32'(vis_a), 1);
    en_a = 0;
    tick();
    cmp("hold.fs", 32'(fs_a), 0);
    cmp("hold.ls", 32'(ls_a), 0);
    cmp("hold.x", 32'(x_a), 0);

    // Step through line 0 and into line 1 at full rate
    en_a = 1;
    fall_x = -1; rise_x = -1; visfall_x = -1; ls_y = -1; ls_x = -1;
    prev_hs = hsync_a; prev_vis = vis_a;
    for (int i = 0; i < 1610; i++) begin
      tick();
      if (prev_hs && !hsync_a && fall_x < 0) fall_x = int'(x_a);
      if (!prev_hs && hsync_a && rise_x < 0) rise_x = int'(x_a);
      if (prev_vis && !vis_a && visfall_x < 0) visfall_x = int'(x_a);
      if (ls_a && ls_y < 0) begin ls_y = int'(y_a); ls_x = int'(x_a); end
      prev_hs = hsync_a; prev_vis = vis_a;
    end
    cmp("hsync.fall_x", 32'(fall_x), 656);
    cmp("hsync.rise_x", 32'(rise_x), 752);
    cmp("visible.fall_x", 32'(visfall_x), 640);
    cmp("wrap.ls_y", 32'(ls_y), 1);
    cmp("wrap.ls_x", 32'(ls_x), 0);

    // One line of enables at 1-in-4: hsync low spans 96 enables of 4 clk each
    low_cnt = 0;
    for (int i = 0; i < 3200; i++) begin
      en_a = (i % 4 == 0);
      tick();
      if (!hsync_a) low_cnt++;
    end
    cmp("gate.hsync_low_clk", 32'(low_cnt), 384);
    en_a = 0;

    // Small raster: full frame from (0,0) back to (0,0)
    rst_b = 1; tick(); tick();
    rst_b = 0; en_b = 1; tick();
    cmp("b.first.fs", 32'(fs_b), 1);
    n_fs = 0; n_ls = 0; n_vs = 0; n_vis = 0;
    for (int i = 0; i < ftot(gb); i++) begin
      tick();
      n_fs += int'(fs_b);
      n_ls += int'(ls_b);
      n_vs += int'(!vsync_b);
      n_vis += int'(vis_b);
    end
    cmp("frame.fs_count", 32'(n_fs), 1);
    cmp("frame.ls_count", 32'(n_ls), 10);
    cmp("frame.vsync_cycles", 32'(n_vs), 30);
    cmp("frame.visible_cycles", 32'(n_vis), 48);
    cmp("frame.end_x", 32'(x_b), 0);
    cmp("frame.end_y", 32'(y_b), 0);

    // Frame period under 1-in-4 enable, measured between frame_start pulses
    rst_b = 1; tick();
    rst_b = 0;
    fs1 = -1; fs2 = -1;
    for (int i = 0; i < 620; i++) begin
      en_b = (i % 4 == 0);
      tick();
      if (fs_b) begin
        if (fs1 < 0) fs1 = i;
        else if (fs2 < 0) fs2 = i;
      end
    end
    cmp("gate.frame_period_clk", 32'(fs2 - fs1), 600);

    // Mid-frame reset while both syncs are active
    rst_b = 1; tick();
    rst_b = 0; en_b = 1;
    repeat (132) tick();
    cmp("mid.x", 32'(x_b), 11);
    cmp("mid.y", 32'(y_b), 8);
    cmp("mid.hsync_active", 32'(hsync_b), 1);
    cmp("mid.vsync_active", 32'(vsync_b), 0);
    rst_b = 1; tick();
    cmp("mid.rst_x", 32'(x_b), 14);
    cmp("mid.rst_y", 32'(y_b), 9);
    cmp("mid.rst_hsync", 32'(hsync_b), 0);
    cmp("mid.rst_vsync", 32'(vsync_b), 1);
    rst_b = 0; tick();
    cmp("mid.after_fs", 32'(fs_b), 1);
    cmp("mid.after_x", 32'(x_b), 0);

    // Random enable and occasional reset on both instances
    for (int i = 0; i < 3000; i++) begin
      en_a  = 1'($urandom_range(1, 0));
      en_b  = 1'($urandom_range(1, 0));
      rst_a = ($urandom_range(63, 0) == 0);
      rst_b = ($urandom_range(63, 0) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
